hw_loop_counter: RTL and testbench

- 32-bit hardware loop counter for the Extended DLX TinyML loop extension.
- Preloads with the one's-complement of (iterations-1), increments once per completed loop iteration, and terminates when the count reaches all-ones.
- Drives the 32-bit count and its qualifier to the downstream all-ones/last-iteration detector, and signals loop completion to the control FSM.

---
 rtl/hw_loop_counter_pkg.sv | 13 +
 rtl/hw_loop_counter_inc32.sv | 17 +
 rtl/hw_loop_counter.sv | 89 ++++++++
 tb/tb_hw_loop_counter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/hw_loop_counter_pkg.sv
// Shared definitions for the hardware loop counter: FSM state encodings
// and the terminal count value.
package hw_loop_counter_pkg;

  typedef enum logic [1:0] {
    HWL_IDLE = 2'd0,
    HWL_RUN  = 2'd1,
    HWL_DONE = 2'd2
  } hwl_state_e;

  localparam logic [31:0] HWL_ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/hw_loop_counter_inc32.sv
// Combinational +1 incrementer producing the next loop count.
module inc32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Unsigned add of one; wrap is unreachable because the caller checks
  // for all-ones before taking the incremented value.
  always_comb begin
    y = a + ONE;
  end

endmodule

// File: rtl/hw_loop_counter.sv
// Hardware loop counter: preloaded with ~(N-1), counts up once per
// completed iteration and finishes when the count is all-ones.
module hw_loop_counter
  import hw_loop_counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] INIT,
  input  logic             STEP,
  input  logic             ABORT,
  output logic [WIDTH-1:0] CNT,
  output logic             CNT_VALID,
  output logic             BUSY,
  output logic             DONE
);

  hwl_state_e       state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic             cnt_last;

  inc32 #(.WIDTH(WIDTH)) u_inc (
    .a (cnt),
    .y (cnt_inc)
  );

  // Terminal detect: the final iteration is the one taken at all-ones.
  always_comb begin
    cnt_last = &cnt;
  end

  // Next-state and next-count decode; ABORT wins over STEP in RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      HWL_IDLE: begin
        if (START && !ABORT) begin
          cnt_nxt   = INIT;
          state_nxt = HWL_RUN;
        end
      end
      HWL_RUN: begin
        if (ABORT) begin
          cnt_nxt   = '0;
          state_nxt = HWL_IDLE;
        end else if (STEP) begin
          if (cnt_last) begin
            state_nxt = HWL_DONE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      HWL_DONE: begin
        state_nxt = HWL_IDLE;
        if (ABORT) begin
          cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = HWL_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and count registers; reset returns to an empty idle loop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= HWL_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    CNT       = cnt;
    CNT_VALID = (state == HWL_RUN);
    BUSY      = (state != HWL_IDLE);
    DONE      = (state == HWL_DONE);
  end

endmodule

// File: tb/tb_hw_loop_counter.sv
// Directed bench for hw_loop_counter: a vector table walked one cycle per
// entry, followed by a hand-written multi-iteration loop sequence.
module tb_hw_loop_counter;
  import hw_loop_counter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] init;
  logic        step;
  logic        abort;
  logic [31:0] cnt;
  logic        cnt_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int passed = 0;

  hw_loop_counter #(.WIDTH(32)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .START     (start),
    .INIT      (init),
    .STEP      (step),
    .ABORT     (abort),
    .CNT       (cnt),
    .CNT_VALID (cnt_valid),
    .BUSY      (busy),
    .DONE      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic [31:0] init;
    logic        step;
    logic        abort;
    logic [31:0] e_cnt;
    logic        e_valid;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic [31:0] i,
                              input logic st, input logic ab, input logic [31:0] ec,
                              input logic ev, input logic eb, input logic ed);
    vec_t v;
    v.rst = r; v.start = s; v.init = i; v.step = st; v.abort = ab;
    v.e_cnt = ec; v.e_valid = ev; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    int  steps;
    bit  got_done;

    rst = 1'b1; start = 1'b0; init = '0; step = 1'b0; abort = 1'b0;

    //           rst start init          step abort exp_cnt       vld busy done
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         0, 0, 0)); // 0 reset
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 0, 0)); // 1 idle
    vecs.push_back(mk(0, 1, 32'hFFFFFFFD, 0, 0, 32'hFFFFFFFD,  1, 1, 0)); // 2 start 3 iters
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'hFFFFFFFE,  1, 1, 0)); // 3 step 1
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'hFFFFFFFF,  1, 1, 0)); // 4 step 2
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'hFFFFFFFF,  0, 1, 1)); // 5 step 3 -> done
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'hFFFFFFFF,  0, 0, 0)); // 6 idle again
    vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF,  1, 1, 0)); // 7 start 1 iter
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'hFFFFFFFF,  0, 1, 1)); // 8 single step
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'hFFFFFFFF,  0, 0, 0)); // 9
    vecs.push_back(mk(0, 1, 32'h00000005, 0, 0, 32'h00000005,  1, 1, 0)); // 10 start at 5
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0,         0, 0, 0)); // 11 step+abort
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 0, 0)); // 12 no done
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 0)); // 13 idle step
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 0)); // 14
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 0)); // 15
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 0)); // 16
    vecs.push_back(mk(0, 1, 32'hFFFFFFF0, 0, 0, 32'hFFFFFFF0,  1, 1, 0)); // 17 start
    vecs.push_back(mk(0, 1, 32'h12345678, 0, 0, 32'hFFFFFFF0,  1, 1, 0)); // 18 start in run
    vecs.push_back(mk(0, 1, 32'h12345678, 1, 0, 32'hFFFFFFF1,  1, 1, 0)); // 19 start+step
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0,         0, 0, 0)); // 20 abort
    vecs.push_back(mk(0, 1, 32'hFFFFFFFE, 0, 0, 32'hFFFFFFFE,  1, 1, 0)); // 21 start
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,         0, 0, 0)); // 22 reset+step
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 0, 0)); // 23
    vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF,  1, 1, 0)); // 24 start 1 iter
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'hFFFFFFFF,  0, 1, 1)); // 25 -> done
    vecs.push_back(mk(0, 1, 32'h0000000A, 0, 1, 32'h0,         0, 0, 0)); // 26 abort in done
    vecs.push_back(mk(0, 1, 32'hFFFFFFFE, 0, 0, 32'hFFFFFFFE,  1, 1, 0)); // 27 start 2 iters
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'hFFFFFFFF,  1, 1, 0)); // 28
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'hFFFFFFFF,  0, 1, 1)); // 29 -> done
    vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 1, 0, 32'hFFFFFFFF,  0, 0, 0)); // 30 start in done
    vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC,  1, 1, 0)); // 31 start next

    for (int i = 0; i < vecs.size(); i++) begin
      rst   = vecs[i].rst;
      start = vecs[i].start;
      init  = vecs[i].init;
      step  = vecs[i].step;
      abort = vecs[i].abort;
      @(posedge clk);
      #1;
      check($sformatf("v%0d cnt", i),   cnt,       vecs[i].e_cnt);
      check($sformatf("v%0d valid", i), {31'b0, cnt_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d busy", i),  {31'b0, busy},      {31'b0, vecs[i].e_busy});
      check($sformatf("v%0d done", i),  {31'b0, done},      {31'b0, vecs[i].e_done});
    end

    // Eight-iteration loop with STEP held high, checking the detector
    // contract each RUN cycle, then a START immediately after DONE.
    rst = 1'b0; start = 1'b0; step = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b1; init = ~32'd7;
    @(posedge clk); #1;
    start = 1'b0; step = 1'b1;
    steps = 0;
    got_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      check($sformatf("det step%0d", steps), {31'b0, (&cnt) & cnt_valid},
            {31'b0, (steps == 7)});
      @(posedge clk); #1;
      steps++;
    end
    check("done seen", {31'b0, got_done}, 32'd1);
    check("iterations", steps, 32'd8);
    check("cnt in done", cnt, HWL_ALL_ONES);
    step = 1'b0;
    @(posedge clk); #1;
    check("idle after done", {31'b0, busy}, 32'd0);
    start = 1'b1; init = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b busy", {31'b0, busy}, 32'd1);
    check("b2b valid", {31'b0, cnt_valid}, 32'd1);
    check("b2b cnt", cnt, 32'hFFFFFFFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
